// File: rtl/alu_kontrol_id_ex.sv
// ID/EX producer for the RV32I ALU: decodes instr into ALU_CNTR/s1/s2 and registers them in one stage.
// Latency 1 cycle accept->out_valid; in_ready = !out_valid || out_ready, outputs hold while stalled, flush wins.
// Optional: ALU_ID_EX_BYPASS_EN adds wb_en/wb_rd/wb_data forwarding onto the rs1/rs2 operand sources.
module alu_kontrol_id_ex #(
  parameter int DATA_WIDTH = 32,
  parameter int ALU_CNTR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
`ifdef ALU_ID_EX_BYPASS_EN
  input  logic                  wb_en,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
`endif
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] s1,
  output logic [DATA_WIDTH-1:0] s2,
  output logic [ALU_CNTR_W-1:0] ALU_CNTR,
  output logic [4:0]            out_rd,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic                  out_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_OR   = 4'b0010, ALU_AND  = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SLL  = 4'b0101, ALU_SRL  = 4'b0110, ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000, ALU_SLTU = 4'b1001, ALU_EQ   = 4'b1010, ALU_GE   = 4'b1011,
    ALU_LT   = 4'b1100, ALU_NE   = 4'b1101, ALU_LTU  = 4'b1110, ALU_GEU  = 4'b1111
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] s1;
    logic [DATA_WIDTH-1:0] s2;
    logic [DATA_WIDTH-1:0] pc;
    alu_op_t               op;
    logic [4:0]            rd;
    logic                  illegal;
  } stage_t;

  // Shared f3 map of OP and OP-IMM; only OP may turn ADD into SUB.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic f7b5, input logic allow_sub);
    alu_op_t r;
    case (f3)
      3'b000:  r = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  logic [6:0]            opcode;
  logic [2:0]            f3;
  logic                  f7b5;
  logic signed [11:0]    imm_i12;
  logic signed [11:0]    imm_s12;
  logic signed [31:0]    imm_u32;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;
  stage_t                dec;
  stage_t                q;
  logic                  out_valid_q;
  logic                  load;

  assign opcode  = instr[6:0];
  assign f3      = instr[14:12];
  assign f7b5    = instr[30];
  assign imm_i12 = instr[31:20];
  assign imm_s12 = {instr[31:25], instr[11:7]};
  assign imm_u32 = {instr[31:12], 12'h000};
  assign imm_i   = DATA_WIDTH'(imm_i12);
  assign imm_s   = DATA_WIDTH'(imm_s12);
  assign imm_u   = DATA_WIDTH'(imm_u32);

`ifdef ALU_ID_EX_BYPASS_EN
  // A writeback landing this cycle is newer than the register file read.
  assign src1 = (wb_en && (wb_rd != 5'd0) && (wb_rd == instr[19:15])) ? wb_data : rs1_data;
  assign src2 = (wb_en && (wb_rd != 5'd0) && (wb_rd == instr[24:20])) ? wb_data : rs2_data;
`else
  assign src1 = rs1_data;
  assign src2 = rs2_data;
`endif

  always_comb begin
    dec         = '0;
    dec.op      = ALU_ADD;
    dec.rd      = instr[11:7];
    dec.pc      = pc;
    dec.illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.op = arith_op(f3, f7b5, 1'b1);
        dec.s1 = src1;
        dec.s2 = src2;
      end
      OPC_OP_IMM: begin
        dec.op = arith_op(f3, f7b5, 1'b0);
        dec.s1 = src1;
        dec.s2 = imm_i;
      end
      OPC_BRANCH: begin
        dec.rd = 5'd0;
        dec.s1 = src1;
        dec.s2 = src2;
        case (f3)
          3'b000:  dec.op = ALU_EQ;
          3'b001:  dec.op = ALU_NE;
          3'b100:  dec.op = ALU_LT;
          3'b101:  dec.op = ALU_GE;
          3'b110:  dec.op = ALU_LTU;
          3'b111:  dec.op = ALU_GEU;
          default: begin
            // Undefined branch condition is treated like any undecodable instruction.
            dec.illegal = 1'b1;
            dec.op      = ALU_ADD;
            dec.s1      = '0;
            dec.s2      = '0;
          end
        endcase
      end
      OPC_LOAD, OPC_JALR: begin
        dec.s1 = src1;
        dec.s2 = imm_i;
      end
      OPC_STORE: begin
        dec.rd = 5'd0;
        dec.s1 = src1;
        dec.s2 = imm_s;
      end
      OPC_LUI: begin
        dec.s1 = '0;
        dec.s2 = imm_u;
      end
      OPC_AUIPC: begin
        dec.s1 = pc;
        dec.s2 = imm_u;
      end
      OPC_JAL: begin
        dec.s1 = pc;
        dec.s2 = DATA_WIDTH'(4);
      end
      default: begin
        dec.illegal = 1'b1;
        dec.rd      = 5'd0;
      end
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      q           <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      q           <= dec;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign s1          = q.s1;
  assign s2          = q.s2;
  assign ALU_CNTR    = ALU_CNTR_W'(q.op);
  assign out_rd      = q.rd;
  assign out_pc      = q.pc;
  assign out_illegal = q.illegal;

endmodule

// File: tb/tb_alu_kontrol_id_ex.sv
// Directed bench for alu_kontrol_id_ex: hand-decoded instructions, handshake, flush and async reset.
module tb_alu_kontrol_id_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s1;
  logic [31:0] s2;
  logic [3:0]  alu_cntr;
  logic [4:0]  out_rd;
  logic [31:0] out_pc;
  logic        out_illegal;
`ifdef ALU_ID_EX_BYPASS_EN
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_kontrol_id_ex #(.DATA_WIDTH(32), .ALU_CNTR_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef ALU_ID_EX_BYPASS_EN
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .s1(s1), .s2(s2), .ALU_CNTR(alu_cntr),
    .out_rd(out_rd), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = 32'h0; pc = 32'h0;
    rs1_data = 32'h0; rs2_data = 32'h0; flush = 1'b0; out_ready = 1'b1;
`ifdef ALU_ID_EX_BYPASS_EN
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
`endif
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_s1", s1, 32'd0);
    chk("rst_cntr", 32'(alu_cntr), 32'd0);
    tick();
    rst = 1'b0;

    // sub x10,x10,x11
    in_valid = 1'b1; instr = 32'h40B50533; rs1_data = 32'd9; rs2_data = 32'd4;
    #1;
    chk("sub_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_cntr", 32'(alu_cntr), 32'b0001);
    chk("sub_s1", s1, 32'd9);
    chk("sub_s2", s2, 32'd4);
    chk("sub_rd", 32'(out_rd), 32'd10);
    chk("sub_ill", 32'(out_illegal), 32'd0);

    // srai x1,x1,2 back-to-back
    instr = 32'h4020D093; rs1_data = 32'h80;
    tick();
    chk("srai_valid", 32'(out_valid), 32'd1);
    chk("srai_cntr", 32'(alu_cntr), 32'b0111);
    chk("srai_s1", s1, 32'h80);
    chk("srai_s2", s2, 32'h00000402);
    chk("srai_rd", 32'(out_rd), 32'd1);

    // beq x0,x0,-4
    instr = 32'hFE000EE3; rs1_data = 32'h11; rs2_data = 32'h22;
    tick();
    chk("beq_cntr", 32'(alu_cntr), 32'b1010);
    chk("beq_rd", 32'(out_rd), 32'd0);
    chk("beq_s2", s2, 32'h22);

    // backpressure: and x5,x6,x7 waits while beq is held
    out_ready = 1'b0; instr = 32'h007372B3; rs1_data = 32'hF0; rs2_data = 32'h3C;
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_cntr", 32'(alu_cntr), 32'b1010);
      chk("bp_s1", s1, 32'h11);
      chk("bp_in_ready2", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("and_valid", 32'(out_valid), 32'd1);
    chk("and_cntr", 32'(alu_cntr), 32'b0011);
    chk("and_s1", s1, 32'hF0);
    chk("and_s2", s2, 32'h3C);
    chk("and_rd", 32'(out_rd), 32'd5);

    // flush while holding with a new instruction offered
    out_ready = 1'b0; flush = 1'b1; instr = 32'h40B50533;
    tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush_nodeliver", 32'(out_valid), 32'd0);

    // auipc x7,0x12345
    in_valid = 1'b1; pc = 32'h100; instr = 32'h12345397;
    tick();
    chk("auipc_s1", s1, 32'h100);
    chk("auipc_s2", s2, 32'h12345000);
    chk("auipc_cntr", 32'(alu_cntr), 32'd0);
    chk("auipc_pc", out_pc, 32'h100);

    // jal x1,0
    instr = 32'h000000EF;
    tick();
    chk("jal_s1", s1, 32'h100);
    chk("jal_s2", s2, 32'd4);
    chk("jal_cntr", 32'(alu_cntr), 32'd0);
    chk("jal_rd", 32'(out_rd), 32'd1);

    // lui x2,0xABCDE
    instr = 32'hABCDE137; rs1_data = 32'h55;
    tick();
    chk("lui_s1", s1, 32'd0);
    chk("lui_s2", s2, 32'hABCDE000);

    // sw x2,-4(x1): negative S-immediate
    instr = 32'hFE20AE23; rs1_data = 32'h1000;
    tick();
    chk("sw_s1", s1, 32'h1000);
    chk("sw_s2", s2, 32'hFFFFFFFC);
    chk("sw_rd", 32'(out_rd), 32'd0);

    // illegal opcode 0x7F
    instr = 32'h0000007F; rs1_data = 32'd5; rs2_data = 32'd6;
    tick();
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_s1", s1, 32'd0);
    chk("ill_s2", s2, 32'd0);

    // branch with f3=010
    instr = 32'h00002063;
    tick();
    chk("br010_ill", 32'(out_illegal), 32'd1);

`ifdef ALU_ID_EX_BYPASS_EN
    // addi x9,x5,1 with x5 being written back
    instr = 32'h00128493; rs1_data = 32'h11; wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hAA;
    tick();
    chk("byp_s1", s1, 32'hAA);
    // addi x9,x0,1 with wb_rd=0: no forwarding
    instr = 32'h00100493; wb_rd = 5'd0;
    tick();
    chk("byp_x0_s1", s1, 32'h11);
    wb_en = 1'b0;
`endif

    // async reset mid-hold
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("hold_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_s1", s1, 32'd0);
    chk("arst_s2", s2, 32'd0);
    chk("arst_cntr", 32'(alu_cntr), 32'd0);
    chk("arst_rd", 32'(out_rd), 32'd0);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_ill", 32'(out_illegal), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_kontrol_id_ex.md
Name: alu_kontrol_id_ex

Overview:
- Producer end of the ALU operand/control interface, located at the decode→execute boundary of the RV32I core.
- Decodes a 32-bit instruction into a 4-bit ALU control code.
- Builds the s1/s2 operands from register data, PC and the immediate.
- Registers the result in a single ID/EX stage with a valid/ready handshake and flush. The stage outputs connect directly to the ALU s1/s2/ALU_CNTR inputs.

Parameters:
- DATA_WIDTH, 32, operand and PC width.
- ALU_CNTR_W, 4, ALU control code width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- instr  in  32  instruction word.
- pc  in  DATA_WIDTH  PC of instr.
- rs1_data  in  DATA_WIDTH  register file read port 1.
- rs2_data  in  DATA_WIDTH  register file read port 2.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  s1/s2/ALU_CNTR are valid.
- out_ready  in  1  execute stage consumes this cycle.
- s1  out  DATA_WIDTH  ALU operand 1.
- s2  out  DATA_WIDTH  ALU operand 2.
- ALU_CNTR  out  ALU_CNTR_W  ALU operation code.
- out_rd  out  5  destination register (instr[11:7]); 0 for BRANCH and STORE.
- out_pc  out  DATA_WIDTH  registered PC.
- out_illegal  out  1  instruction not decodable.

Behaviour:
- ALU codes:
  - ADD 0000, SUB 0001, OR 0010, AND 0011, XOR 0100.
  - SLL 0101, SRL 0110, SRA 0111.
  - SLT 1000, SLTU 1001.
  - EQ 1010, GE 1011, LT 1100, NE 1101, LTU 1110, GEU 1111.
- Reset (async, rst=1): out_valid=0. s1, s2, ALU_CNTR, out_rd, out_pc, out_illegal all 0. A reset mid-transfer drops the held instruction.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Load occurs when in_valid && in_ready && !flush.
  - Latency is 1 cycle from accept to out_valid.
  - While out_valid && !out_ready, all outputs hold stable.
- Flush: the next edge sets out_valid=0 and accepts nothing. Flush has priority over load and over hold. Data registers need not clear on flush.
- Valid bookkeeping on each edge without flush:
  - out_valid ← 1 on load.
  - Otherwise out_valid ← 0 if out_ready.
  - Otherwise out_valid holds.
- Back-to-back: with out_ready=1, one instruction per cycle.
- Decode by opcode instr[6:0], with f3=instr[14:12] and f7b5=instr[30]:
  - OP 0110011, s1=rs1, s2=rs2:
    - f3 000 → ADD, or SUB if f7b5=1.
    - 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
    - 101 → SRL, or SRA if f7b5=1.
    - 110 OR; 111 AND.
  - OP-IMM 0010011, s1=rs1, s2=I-imm (sign-extended instr[31:20]): same f3 map as OP, except f3 000 is always ADD. f7b5 selects SRL/SRA only.
  - BRANCH 1100011, s1=rs1, s2=rs2:
    - f3 000 EQ; 001 NE; 100 LT; 101 GE; 110 LTU; 111 GEU.
    - f3 010/011 are illegal.
  - LOAD 0000011 / JALR 1100111: ADD, s1=rs1, s2=I-imm.
  - STORE 0100011: ADD, s1=rs1, s2=S-imm ({instr[31:25],instr[11:7]} sign-extended).
  - LUI 0110111: ADD, s1=0, s2={instr[31:12],12'b0}.
  - AUIPC 0010111: ADD, s1=pc, s2=U-imm.
  - JAL 1101111: ADD, s1=pc, s2=4 (link value).
  - Any other opcode: out_illegal=1, ALU_CNTR=ADD, s1=s2=0, out_rd=0. The instruction is still handshaked normally.
- Shift amount: s2 carries the full I-imm; the ALU uses s2[4:0].

Optional Feature:
- Macro: ALU_ID_EX_BYPASS_EN.
- Defined: adds inputs wb_en (1), wb_rd (5) and wb_data (DATA_WIDTH).
  - When wb_en=1, wb_rd!=0 and wb_rd==instr[19:15] in the load cycle, s1 takes wb_data in place of rs1_data.
  - The same rule applies to s2 when the s2 source is rs2 and wb_rd==instr[24:20].
  - The bypass affects only the rs1/rs2 source selections.
- Undefined: the ports are absent and operands always come from rs1_data/rs2_data.

Test Plan:
- Reset: assert rst mid-hold with out_valid=1 → out_valid=0 and all outputs 0 immediately, before any clock edge.
- Type check, out_ready=1:
  - instr 0x40B50533 (sub x10,x10,x11), rs1_data=9, rs2_data=4 → next cycle out_valid=1, ALU_CNTR=0001, s1=9, s2=4, out_rd=10.
  - instr 0x4020D093 (srai x1,x1,2) → ALU_CNTR=0111, s2=0x00000402.
  - instr 0xFE000EE3 (beq x0,x0,-4) → ALU_CNTR=1010, out_rd=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Raise out_ready → the queued instruction is accepted that cycle and appears the next cycle.
- Flush: flush=1 with in_valid=1 while holding → next cycle out_valid=0 and the incoming instruction is not delivered.
- AUIPC/JAL: pc=0x100, auipc 0x12345 → s1=0x100, s2=0x12345000. jal → s1=0x100, s2=4, ALU_CNTR=0000.
- Illegal:
  - opcode 0x7F → out_illegal=1, s1=s2=0.
  - BRANCH with f3=010 → out_illegal=1.
  - With ALU_ID_EX_BYPASS_EN, wb_rd=instr[19:15]=5, wb_data=0xAA → s1=0xAA. With wb_rd=0, no bypass occurs.
